// File: rtl/bus_arbiter_2core.sv
// Two-core shared-bus arbiter with snoop routing and cache_hit/flush cross-routing.
// Optional hold-time limit enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_2core #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int MAX_HOLD = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_core0,
   input  logic              req_core1,
   output logic              grant0,
   output logic              grant1,
   input  logic [DATA_W-1:0] bus_data_from0,
   input  logic [DATA_W-1:0] bus_data_from1,
   input  logic [ADDR_W-1:0] bus_address_from0,
   input  logic [ADDR_W-1:0] bus_address_from1,
   input  logic [1:0]        bus_op_from0,
   input  logic [1:0]        bus_op_from1,
   output logic [DATA_W-1:0] bus_data_to0,
   output logic [DATA_W-1:0] bus_data_to1,
   output logic [ADDR_W-1:0] bus_address_to0,
   output logic [ADDR_W-1:0] bus_address_to1,
   output logic [1:0]        bus_op_to0,
   output logic [1:0]        bus_op_to1,
   input  logic              cache_hit_from0,
   input  logic              cache_hit_from1,
   output logic              cache_hit_to0,
   output logic              cache_hit_to1,
   input  logic              flush_from0,
   input  logic              flush_from1,
   output logic              flush_to_owner,
   output logic              timeout
);

   localparam logic [1:0] OP_NONE = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   last_owner, last_owner_nxt;
   logic   timeout_q, timeout_nxt;
   logic   hold_expired;

   // Round-robin tie break: the core that did not own the bus last wins.
   function automatic state_t arbitrate(input logic r0, input logic r1, input logic lo);
      if (r0 && r1)  return lo ? OWN0 : OWN1;
      else if (r0)   return OWN0;
      else if (r1)   return OWN1;
      else           return IDLE;
   endfunction

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   logic [CNT_W-1:0] hold_cnt;

   assign hold_expired = (hold_cnt == CNT_W'(MAX_HOLD - 1));

   // Any state change (including a direct OWN0<->OWN1 handoff) restarts the count.
   always_ff @(posedge clk) begin
      if (reset)
         hold_cnt <= '0;
      else if (state_nxt != state)
         hold_cnt <= '0;
      else if (state != IDLE)
         hold_cnt <= hold_cnt + 1'b1;
   end
`else
   assign hold_expired = 1'b0;
`endif

   always_comb begin
      state_nxt      = state;
      last_owner_nxt = last_owner;
      timeout_nxt    = 1'b0;
      case (state)
         IDLE: state_nxt = arbitrate(req_core0, req_core1, last_owner);
         OWN0: begin
            if (!req_core0) begin
               last_owner_nxt = 1'b0;
               state_nxt      = req_core1 ? OWN1 : IDLE;
            end else if (hold_expired) begin
               last_owner_nxt = 1'b0;
               state_nxt      = IDLE;
               timeout_nxt    = 1'b1;
            end
         end
         OWN1: begin
            if (!req_core1) begin
               last_owner_nxt = 1'b1;
               state_nxt      = req_core0 ? OWN0 : IDLE;
            end else if (hold_expired) begin
               last_owner_nxt = 1'b1;
               state_nxt      = IDLE;
               timeout_nxt    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         timeout_q  <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_owner <= last_owner_nxt;
         timeout_q  <= timeout_nxt;
      end
   end

   assign grant0  = (state == OWN0);
   assign grant1  = (state == OWN1);
   assign timeout = timeout_q;

   // Owner sees its own address echoed and any snooper data; snooper sees the owner's request.
   always_comb begin
      bus_data_to0    = '0;
      bus_data_to1    = '0;
      bus_address_to0 = '0;
      bus_address_to1 = '0;
      bus_op_to0      = OP_NONE;
      bus_op_to1      = OP_NONE;
      flush_to_owner  = 1'b0;
      case (state)
         OWN0: begin
            bus_data_to1    = bus_data_from0;
            bus_address_to1 = bus_address_from0;
            bus_op_to1      = bus_op_from0;
            bus_data_to0    = bus_data_from1;
            bus_address_to0 = bus_address_from0;
            flush_to_owner  = flush_from1;
         end
         OWN1: begin
            bus_data_to0    = bus_data_from1;
            bus_address_to0 = bus_address_from1;
            bus_op_to0      = bus_op_from1;
            bus_data_to1    = bus_data_from0;
            bus_address_to1 = bus_address_from1;
            flush_to_owner  = flush_from0;
         end
         default: ;
      endcase
   end

   assign cache_hit_to0 = cache_hit_from1;
   assign cache_hit_to1 = cache_hit_from0;

endmodule

// File: tb/tb_bus_arbiter_2core.sv
// Directed self-checking bench for bus_arbiter_2core; timeout expectations follow ARB_TIMEOUT_EN.
module tb_bus_arbiter_2core;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;

   logic clk = 1'b0;
   logic reset;
   logic req_core0, req_core1;
   logic grant0, grant1;
   logic [DATA_W-1:0] bus_data_from0, bus_data_from1, bus_data_to0, bus_data_to1;
   logic [ADDR_W-1:0] bus_address_from0, bus_address_from1, bus_address_to0, bus_address_to1;
   logic [1:0] bus_op_from0, bus_op_from1, bus_op_to0, bus_op_to1;
   logic cache_hit_from0, cache_hit_from1, cache_hit_to0, cache_hit_to1;
   logic flush_from0, flush_from1, flush_to_owner, timeout;

   int total = 0;
   int bad   = 0;

   bus_arbiter_2core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_HOLD(4)) dut (
      .clk(clk), .reset(reset),
      .req_core0(req_core0), .req_core1(req_core1),
      .grant0(grant0), .grant1(grant1),
      .bus_data_from0(bus_data_from0), .bus_data_from1(bus_data_from1),
      .bus_address_from0(bus_address_from0), .bus_address_from1(bus_address_from1),
      .bus_op_from0(bus_op_from0), .bus_op_from1(bus_op_from1),
      .bus_data_to0(bus_data_to0), .bus_data_to1(bus_data_to1),
      .bus_address_to0(bus_address_to0), .bus_address_to1(bus_address_to1),
      .bus_op_to0(bus_op_to0), .bus_op_to1(bus_op_to1),
      .cache_hit_from0(cache_hit_from0), .cache_hit_from1(cache_hit_from1),
      .cache_hit_to0(cache_hit_to0), .cache_hit_to1(cache_hit_to1),
      .flush_from0(flush_from0), .flush_from1(flush_from1),
      .flush_to_owner(flush_to_owner), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; req_core0 = 1'b0; req_core1 = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      bus_data_from0 = 32'h1111_1111; bus_data_from1 = 32'h2222_2222;
      bus_address_from0 = 32'h100; bus_address_from1 = 32'h200;
      bus_op_from0 = 2'b00; bus_op_from1 = 2'b00;
      cache_hit_from0 = 1'b0; cache_hit_from1 = 1'b0;
      flush_from0 = 1'b1; flush_from1 = 1'b1;
      do_reset();
      total++;
      if ({grant0, grant1, timeout} !== 3'b000) begin
         bad++; $display("FAIL reset_grants got=%b want=000", {grant0, grant1, timeout});
      end
      total++;
      if ({bus_op_to0, bus_op_to1} !== 4'b1111 || bus_data_to0 !== 0 || bus_data_to1 !== 0 ||
          bus_address_to0 !== 0 || bus_address_to1 !== 0 || flush_to_owner !== 1'b0) begin
         bad++; $display("FAIL reset_routing op=%b d0=%h d1=%h a0=%h a1=%h fl=%b want op=1111 rest 0",
                         {bus_op_to0, bus_op_to1}, bus_data_to0, bus_data_to1,
                         bus_address_to0, bus_address_to1, flush_to_owner);
      end
   endtask

   task automatic test_single_grant();
      do_reset();
      tick();
      req_core0 = 1'b1; bus_op_from0 = 2'b01; flush_from0 = 1'b0; flush_from1 = 1'b0;
      #1;
      total++;
      if (grant0 !== 1'b0) begin
         bad++; $display("FAIL grant_latency got=%b want=0", grant0);
      end
      tick();
      total++;
      if ({grant0, grant1} !== 2'b10 || bus_op_to1 !== 2'b01) begin
         bad++; $display("FAIL single_grant g=%b op_to1=%b want g=10 op_to1=01", {grant0, grant1}, bus_op_to1);
      end
      req_core0 = 1'b0;
      tick();
      total++;
      if ({grant0, grant1} !== 2'b00) begin
         bad++; $display("FAIL single_release g=%b want=00", {grant0, grant1});
      end
   endtask

   task automatic test_tie();
      do_reset();
      req_core0 = 1'b1; req_core1 = 1'b1;
      tick();
      total++;
      if ({grant0, grant1} !== 2'b10) begin
         bad++; $display("FAIL tie_first g=%b want=10", {grant0, grant1});
      end
      req_core0 = 1'b0;
      tick();
      total++;
      if ({grant0, grant1} !== 2'b01) begin
         bad++; $display("FAIL tie_handoff g=%b want=01", {grant0, grant1});
      end
      req_core1 = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [1:0] want;
      do_reset();
      req_core0 = 1'b1; req_core1 = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         want = (k % 2 == 0) ? 2'b10 : 2'b01;
         for (int c = 0; c < 3; c++) begin
            total++;
            if ({grant0, grant1} !== want) begin
               bad++; $display("FAIL b2b_phase%0d_cyc%0d g=%b want=%b", k, c, {grant0, grant1}, want);
            end
            if (c == 2) begin
               if (k % 2 == 0) req_core0 = 1'b0; else req_core1 = 1'b0;
            end
            tick();
         end
         req_core0 = 1'b1; req_core1 = 1'b1;
      end
      req_core0 = 1'b0; req_core1 = 1'b0;
      tick(); tick();
   endtask

   task automatic test_routing();
      do_reset();
      req_core0 = 1'b1;
      tick();
      bus_op_from0 = 2'b10; bus_address_from0 = 32'h0000_0040; bus_data_from0 = 32'h0000_1234;
      bus_op_from1 = 2'b00; bus_address_from1 = 32'h0000_0099; bus_data_from1 = 32'hDEAD_BEEF;
      cache_hit_from0 = 1'b0; cache_hit_from1 = 1'b1; flush_from0 = 1'b0; flush_from1 = 1'b1;
      #1;
      total++;
      if (bus_op_to1 !== 2'b10 || bus_address_to1 !== 32'h40 || bus_data_to1 !== 32'h1234) begin
         bad++; $display("FAIL route_snoop op=%b a=%h d=%h want op=10 a=40 d=1234",
                         bus_op_to1, bus_address_to1, bus_data_to1);
      end
      total++;
      if (bus_op_to0 !== 2'b11 || bus_data_to0 !== 32'hDEAD_BEEF || bus_address_to0 !== 32'h40 ||
          flush_to_owner !== 1'b1) begin
         bad++; $display("FAIL route_owner op=%b d=%h a=%h fl=%b want op=11 d=deadbeef a=40 fl=1",
                         bus_op_to0, bus_data_to0, bus_address_to0, flush_to_owner);
      end
      total++;
      if ({cache_hit_to0, cache_hit_to1} !== 2'b10) begin
         bad++; $display("FAIL route_hit got=%b want=10", {cache_hit_to0, cache_hit_to1});
      end
      cache_hit_from0 = 1'b1; cache_hit_from1 = 1'b0; flush_from1 = 1'b0; flush_from0 = 1'b1;
      #1;
      total++;
      if ({cache_hit_to0, cache_hit_to1, flush_to_owner} !== 3'b010) begin
         bad++; $display("FAIL route_hit_swap got=%b want=010", {cache_hit_to0, cache_hit_to1, flush_to_owner});
      end
      // Non-owner request is ignored, then withdrawn before ever being granted.
      req_core1 = 1'b1;
      tick();
      total++;
      if ({grant0, grant1} !== 2'b10) begin
         bad++; $display("FAIL no_preempt g=%b want=10", {grant0, grant1});
      end
      req_core1 = 1'b0; req_core0 = 1'b0;
      tick();
      total++;
      if ({grant0, grant1, bus_op_to0, bus_op_to1} !== 6'b001111) begin
         bad++; $display("FAIL dropped_req g=%b op=%b want g=00 op=1111", {grant0, grant1}, {bus_op_to0, bus_op_to1});
      end
   endtask

   task automatic test_reset_while_owned();
      do_reset();
      req_core1 = 1'b1; bus_op_from1 = 2'b01;
      tick();
      total++;
      if ({grant0, grant1} !== 2'b01 || bus_op_to0 !== 2'b01) begin
         bad++; $display("FAIL own1 g=%b op_to0=%b want g=01 op_to0=01", {grant0, grant1}, bus_op_to0);
      end
      reset = 1'b1;
      tick();
      total++;
      if ({grant0, grant1} !== 2'b00 || bus_op_to0 !== 2'b11 || bus_data_to0 !== 0) begin
         bad++; $display("FAIL reset_own1 g=%b op_to0=%b d0=%h want g=00 op=11 d0=0", {grant0, grant1}, bus_op_to0, bus_data_to0);
      end
      reset = 1'b0; req_core0 = 1'b1; req_core1 = 1'b1;
      tick();
      total++;
      if ({grant0, grant1} !== 2'b10) begin
         bad++; $display("FAIL reset_tie g=%b want=10", {grant0, grant1});
      end
      req_core0 = 1'b0; req_core1 = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      req_core0 = 1'b1; req_core1 = 1'b1;
      tick();
`ifdef ARB_TIMEOUT_EN
      for (int c = 0; c < 4; c++) begin
         total++;
         if ({grant0, grant1, timeout} !== 3'b100) begin
            bad++; $display("FAIL to_hold%0d g_t=%b want=100", c, {grant0, grant1, timeout});
         end
         tick();
      end
      total++;
      if ({grant0, grant1, timeout} !== 3'b001) begin
         bad++; $display("FAIL to_pulse g_t=%b want=001", {grant0, grant1, timeout});
      end
      tick();
      total++;
      if ({grant0, grant1, timeout} !== 3'b010) begin
         bad++; $display("FAIL to_regrant g_t=%b want=010", {grant0, grant1, timeout});
      end
`else
      for (int c = 0; c < 8; c++) begin
         total++;
         if ({grant0, grant1, timeout} !== 3'b100) begin
            bad++; $display("FAIL no_to_hold%0d g_t=%b want=100", c, {grant0, grant1, timeout});
         end
         tick();
      end
`endif
      req_core0 = 1'b0; req_core1 = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1; req_core0 = 1'b0; req_core1 = 1'b0;
      test_reset();
      test_single_grant();
      test_tie();
      test_back_to_back();
      test_routing();
      test_reset_while_owned();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
